// File: rtl/cpu_params_pkg.sv
// Shared constants for the load/store memory controller: FSM states,
// exception cause codes and the byte-lane enable helper.
package cpu_params_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } ls_state_t;

    localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
    localparam logic [3:0] CAUSE_LD_ACCESS   = 4'd5;
    localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
    localparam logic [3:0] CAUSE_ST_ACCESS   = 4'd7;

    // Byte lanes touched by an access of 1, 2 or 4 bytes at the given word offset.
    function automatic logic [3:0] byte_enable(input logic [2:0] size, input logic [1:0] off);
        case (size)
            3'd1:    return 4'b0001 << off;
            3'd2:    return 4'b0011 << {off[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ld_align.sv
// Load data alignment: moves the addressed bytes of a bus word down to bit 0
// and sign- or zero-extends them to XLEN.
module ld_align #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rd_data,
    input  logic [1:0]      offset,
    input  logic [2:0]      size,
    input  logic            zero_ext,
    output logic [XLEN-1:0] ld_data
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted = rd_data >> {offset, 3'b000};
        case (size)
            3'd1: ld_data = zero_ext ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                                     : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            3'd2: ld_data = zero_ext ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                                     : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

endmodule

// File: rtl/ls_mem_ctrl.sv
// Load/store memory controller: takes one LS request at a time from the EXE
// stage, runs a single word-aligned data bus access and returns a one-cycle response.
module ls_mem_ctrl
    import cpu_params_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk_in,
    input  logic            reset_in,
    // Request: accepted on any cycle where req_valid && req_ready.
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            is_ld,
    input  logic            is_st,
    input  logic [XLEN-1:0] ls_addr,
    input  logic [XLEN-1:0] st_data,
    input  logic [2:0]      size,
    input  logic            zero_ext,
    input  logic            mis,
    input  logic            flush,
    output logic            dbus_req,
    output logic            dbus_rd,
    output logic            dbus_wr,
    output logic [XLEN-1:0] dbus_addr,
    output logic [XLEN-1:0] dbus_wr_data,
    output logic [3:0]      dbus_be,
    input  logic            dbus_ack,
    input  logic            dbus_fault,
    input  logic [XLEN-1:0] dbus_rd_data,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_data,
    output logic            rsp_exc,
    output logic [3:0]      rsp_cause,
    output logic [1:0]      state_dbg
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    ls_state_t       state_q, state_d;
    logic            is_ld_q, is_st_q, zext_q, exc_q, flush_q;
    logic [XLEN-1:0] addr_q, wdata_q, rdata_q, wdata_rep, ld_data;
    logic [2:0]      size_q;
    logic [3:0]      be_q, cause_q;
    logic [CW-1:0]   cnt_q;
    logic            in_bus, in_resp, timeout_hit;

    assign in_bus      = (state_q == ST_BUS);
    assign in_resp     = (state_q == ST_RESP);
    assign timeout_hit = in_bus && (cnt_q == CNT_LAST);

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Ack takes priority over a timeout landing in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_valid) state_d = mis ? ST_RESP : ST_BUS;
            ST_BUS:  if (dbus_ack || timeout_hit) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        case (size)
            3'd1:    wdata_rep = {(XLEN/8){st_data[7:0]}};
            3'd2:    wdata_rep = {(XLEN/16){st_data[15:0]}};
            default: wdata_rep = st_data;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            is_ld_q <= 1'b0;
            is_st_q <= 1'b0;
            zext_q  <= 1'b0;
            exc_q   <= 1'b0;
            flush_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            size_q  <= '0;
            be_q    <= '0;
            cause_q <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    flush_q <= 1'b0;
                    if (req_valid) begin
                        is_ld_q <= is_ld;
                        is_st_q <= is_st;
                        addr_q  <= ls_addr;
                        size_q  <= size;
                        zext_q  <= zero_ext;
                        be_q    <= byte_enable(size, ls_addr[1:0]);
                        wdata_q <= wdata_rep;
                        cnt_q   <= '0;
                        exc_q   <= mis;
                        cause_q <= is_ld ? CAUSE_LD_MISALIGN : CAUSE_ST_MISALIGN;
                    end
                end
                ST_BUS: begin
                    cnt_q <= cnt_q + CW'(1);
                    // A flush cannot abort the bus cycle; it only kills the response.
                    if (flush) flush_q <= 1'b1;
                    if (dbus_ack) begin
                        rdata_q <= dbus_rd_data;
                        exc_q   <= dbus_fault;
                        cause_q <= is_ld_q ? CAUSE_LD_ACCESS : CAUSE_ST_ACCESS;
                    end else if (timeout_hit) begin
                        exc_q   <= 1'b1;
                        cause_q <= is_ld_q ? CAUSE_LD_ACCESS : CAUSE_ST_ACCESS;
                    end
                end
                ST_RESP: flush_q <= 1'b0;
                default: ;
            endcase
        end
    end

    ld_align #(.XLEN(XLEN)) u_ld_align (
        .rd_data  (rdata_q),
        .offset   (addr_q[1:0]),
        .size     (size_q),
        .zero_ext (zext_q),
        .ld_data  (ld_data)
    );

    // Bus outputs are decoded from the state so an async reset drops them at once.
    assign req_ready    = (state_q == ST_IDLE);
    assign dbus_req     = in_bus;
    assign dbus_rd      = in_bus && is_ld_q;
    assign dbus_wr      = in_bus && is_st_q;
    assign dbus_addr    = in_bus ? {addr_q[XLEN-1:2], 2'b00} : '0;
    assign dbus_be      = in_bus ? be_q : '0;
    assign dbus_wr_data = (in_bus && is_st_q) ? wdata_q : '0;

    assign rsp_valid = in_resp && !flush_q && !flush;
    assign rsp_exc   = rsp_valid && exc_q;
    assign rsp_cause = (rsp_valid && exc_q) ? cause_q : 4'd0;
    assign rsp_data  = (rsp_valid && !exc_q && is_ld_q) ? ld_data : '0;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_ls_mem_ctrl.sv
// Bench for ls_mem_ctrl: directed cases plus randomized transactions checked
// against a byte-level reference model of loads, stores and exceptions.
module tb_ls_mem_ctrl;

    localparam int XLEN = 32;
    localparam int TO   = 8;

    logic            clk_in = 1'b0;
    logic            reset_in;
    logic            req_valid, req_ready, is_ld, is_st, zero_ext, mis, flush;
    logic [XLEN-1:0] ls_addr, st_data;
    logic [2:0]      size;
    logic            dbus_req, dbus_rd, dbus_wr, dbus_ack, dbus_fault;
    logic [XLEN-1:0] dbus_addr, dbus_wr_data, dbus_rd_data;
    logic [3:0]      dbus_be;
    logic            rsp_valid, rsp_exc;
    logic [XLEN-1:0] rsp_data;
    logic [3:0]      rsp_cause;
    logic [1:0]      state_dbg;

    int n_checks = 0;
    int n_fail   = 0;
    logic [XLEN-1:0] exp_q[$];

    ls_mem_ctrl #(.XLEN(XLEN), .TIMEOUT(TO)) dut (
        .clk_in(clk_in), .reset_in(reset_in),
        .req_valid(req_valid), .req_ready(req_ready), .is_ld(is_ld), .is_st(is_st),
        .ls_addr(ls_addr), .st_data(st_data), .size(size), .zero_ext(zero_ext),
        .mis(mis), .flush(flush),
        .dbus_req(dbus_req), .dbus_rd(dbus_rd), .dbus_wr(dbus_wr),
        .dbus_addr(dbus_addr), .dbus_wr_data(dbus_wr_data), .dbus_be(dbus_be),
        .dbus_ack(dbus_ack), .dbus_fault(dbus_fault), .dbus_rd_data(dbus_rd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_exc(rsp_exc),
        .rsp_cause(rsp_cause), .state_dbg(state_dbg)
    );

    always #5 clk_in = ~clk_in;

    // ---------------- reference model ----------------
    function automatic logic [3:0] m_be(input int sz, input int off);
        return 4'(((32'd1 << sz) - 1) << off);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [31:0] d, input int sz);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % sz) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] rd, input int off, input int sz,
                                           input bit zext);
        logic [31:0] r = '0;
        for (int i = 0; i < sz; i++) r[8*i +: 8] = rd[8*(off+i) +: 8];
        if (!zext && rd[8*(off+sz)-1])
            for (int i = sz; i < 4; i++) r[8*i +: 8] = 8'hFF;
        return r;
    endfunction

    // ---------------- driver ----------------
    // Starts and ends just after a rising edge with the DUT in IDLE.
    // flush_at: bus cycle index to pulse flush in; nbus means the response cycle; -1 none.
    task automatic run_txn(input bit ld, input logic [31:0] addr, input logic [31:0] sdata,
                           input int sz, input bit zext, input bit misal, input int ack_delay,
                           input bit fault, input logic [31:0] rdata, input int flush_at,
                           output logic [3:0] obs_be, output logic [31:0] obs_wdata,
                           output logic [31:0] obs_data);
        int off, nbus;
        bit acked, exp_valid, exp_exc;
        logic [3:0]  exp_cause;
        logic [31:0] exp_data, exp_wd;
        logic [70:0] exp_bus, got_bus;
        off   = int'(addr[1:0]);
        nbus  = misal ? 0 : ((ack_delay < TO) ? ack_delay + 1 : TO);
        acked = !misal && (ack_delay < TO);
        exp_exc   = misal || !acked || fault;
        exp_cause = misal ? (ld ? 4'd4 : 4'd6) : (exp_exc ? (ld ? 4'd5 : 4'd7) : 4'd0);
        exp_data  = (exp_exc || !ld) ? 32'd0 : m_load(rdata, off, sz, zext);
        exp_valid = !(flush_at >= 0 && flush_at <= nbus);
        exp_wd    = ld ? 32'd0 : m_wdata(sdata, sz);
        exp_q.push_back(exp_data);
        obs_be = '0; obs_wdata = '0; obs_data = '0;

        req_valid = 1'b1; is_ld = ld; is_st = !ld; ls_addr = addr; st_data = sdata;
        size = 3'(sz); zero_ext = zext; mis = misal; flush = 1'b0; dbus_ack = 1'b0;
        @(negedge clk_in);
        n_checks++;
        if ({req_ready, rsp_valid, dbus_req} !== 3'b100) begin
            n_fail++;
            $display("FAIL accept addr=%h got ready/rsp/req=%b exp=100", addr,
                     {req_ready, rsp_valid, dbus_req});
        end
        @(posedge clk_in); #1;
        req_valid = 1'b0; is_ld = 1'b0; is_st = 1'b0;
        ls_addr = $urandom; st_data = $urandom; size = 3'($urandom_range(0, 7));

        for (int k = 0; k < nbus; k++) begin
            flush = (k == flush_at);
            if (acked && k == ack_delay) begin
                dbus_ack = 1'b1; dbus_fault = fault; dbus_rd_data = rdata;
            end else begin
                dbus_ack = 1'b0; dbus_fault = 1'($urandom); dbus_rd_data = $urandom;
            end
            @(negedge clk_in);
            exp_bus = {1'b0, 1'b0, 1'b1, ld, !ld, addr & 32'hFFFF_FFFC, m_be(sz, off), exp_wd};
            got_bus = {req_ready, rsp_valid, dbus_req, dbus_rd, dbus_wr, dbus_addr, dbus_be,
                       dbus_wr_data};
            n_checks++;
            if (got_bus !== exp_bus) begin
                n_fail++;
                $display("FAIL bus_cycle k=%0d addr=%h got=%h exp=%h", k, addr, got_bus, exp_bus);
            end
            obs_be = dbus_be; obs_wdata = dbus_wr_data;
            @(posedge clk_in); #1;
        end

        dbus_ack = 1'b0; dbus_fault = 1'b0; flush = (flush_at == nbus);
        @(negedge clk_in);
        exp_data = exp_q.pop_front();
        n_checks++;
        if ({dbus_req, req_ready, rsp_valid} !== {2'b00, exp_valid}) begin
            n_fail++;
            $display("FAIL resp_cycle addr=%h got req/ready/valid=%b exp=%b", addr,
                     {dbus_req, req_ready, rsp_valid}, {2'b00, exp_valid});
        end
        if (exp_valid) begin
            n_checks++;
            if ({rsp_data, rsp_exc, rsp_cause} !== {exp_data, exp_exc, exp_cause}) begin
                n_fail++;
                $display("FAIL resp_payload addr=%h got data=%h exc=%b cause=%0d exp data=%h exc=%b cause=%0d",
                         addr, rsp_data, rsp_exc, rsp_cause, exp_data, exp_exc, exp_cause);
            end
        end
        obs_data = rsp_data;
        @(posedge clk_in); #1;
        flush = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_in = 1'b1; req_valid = 1'b0; is_ld = 1'b0; is_st = 1'b0; ls_addr = '0;
        st_data = '0; size = '0; zero_ext = 1'b0; mis = 1'b0; flush = 1'b0;
        dbus_ack = 1'b0; dbus_fault = 1'b0; dbus_rd_data = '0;
        #3;
        n_checks++;
        if ({req_ready, dbus_req, dbus_rd, dbus_wr, rsp_valid, rsp_exc, state_dbg} !== 8'b1000_0000 ||
            dbus_addr !== 32'd0 || dbus_wr_data !== 32'd0 || dbus_be !== 4'd0 ||
            rsp_data !== 32'd0 || rsp_cause !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_state ready=%b req=%b addr=%h be=%h rsp=%b data=%h state=%0d exp ready=1 rest 0",
                     req_ready, dbus_req, dbus_addr, dbus_be, rsp_valid, rsp_data, state_dbg);
        end
        @(posedge clk_in); #1;
        reset_in = 1'b0;
    endtask

    task automatic test_directed();
        logic [3:0] be; logic [31:0] wd, d;
        run_txn(1, 32'h1003, 32'h0, 1, 0, 0, 1, 0, 32'h80FF_FF00, -1, be, wd, d);
        n_checks++;
        if (be !== 4'b1000 || d !== 32'hFFFF_FF80) begin
            n_fail++;
            $display("FAIL lb_signext got be=%b data=%h exp be=1000 data=ffffff80", be, d);
        end
        run_txn(0, 32'h2002, 32'h0000_ABCD, 2, 0, 0, 3, 0, 32'h0, -1, be, wd, d);
        n_checks++;
        if (be !== 4'b1100 || wd !== 32'hABCD_ABCD || d !== 32'd0) begin
            n_fail++;
            $display("FAIL sh_replicate got be=%b wdata=%h data=%h exp be=1100 wdata=abcdabcd data=0",
                     be, wd, d);
        end
        run_txn(1, 32'h3001, 32'h0, 4, 0, 1, 0, 0, 32'h0, -1, be, wd, d);
        run_txn(0, 32'h3002, 32'h1234_5678, 4, 0, 1, 0, 0, 32'h0, -1, be, wd, d);
        run_txn(0, 32'h5000, 32'hCAFE_F00D, 4, 0, 0, 1000, 0, 32'h0, -1, be, wd, d);
        run_txn(1, 32'h6004, 32'h0, 4, 0, 0, TO - 1, 0, 32'hDEAD_BEEF, -1, be, wd, d);
        run_txn(1, 32'h7001, 32'h0, 1, 1, 0, 0, 1, 32'hFFFF_FFFF, -1, be, wd, d);
    endtask

    task automatic test_flush();
        logic [3:0] be; logic [31:0] wd, d;
        run_txn(1, 32'h4002, 32'h0, 2, 1, 0, 2, 0, 32'h8001_0000, 1, be, wd, d);
        run_txn(1, 32'h4002, 32'h0, 2, 1, 0, 2, 0, 32'h8001_0000, -1, be, wd, d);
        n_checks++;
        if (d !== 32'h0000_8001) begin
            n_fail++;
            $display("FAIL lhu_after_flush got=%h exp=00008001", d);
        end
        run_txn(1, 32'h4100, 32'h0, 4, 0, 0, 1, 0, 32'h1111_2222, 2, be, wd, d);
        run_txn(0, 32'h4203, 32'h0, 2, 0, 1, 0, 0, 32'h0, 0, be, wd, d);
    endtask

    task automatic test_ack_idle();
        logic [3:0] be; logic [31:0] wd, d;
        for (int i = 0; i < 3; i++) begin
            dbus_ack = 1'b1; dbus_fault = 1'b1; dbus_rd_data = $urandom;
            @(negedge clk_in);
            n_checks++;
            if ({req_ready, dbus_req, rsp_valid} !== 3'b100) begin
                n_fail++;
                $display("FAIL ack_in_idle i=%0d got ready/req/rsp=%b exp=100", i,
                         {req_ready, dbus_req, rsp_valid});
            end
            @(posedge clk_in); #1;
        end
        dbus_ack = 1'b0; dbus_fault = 1'b0;
        run_txn(1, 32'h8000, 32'h0, 4, 0, 0, 0, 0, 32'h0BAD_F00D, -1, be, wd, d);
    endtask

    task automatic test_reset_mid_bus();
        logic [3:0] be; logic [31:0] wd, d;
        req_valid = 1'b1; is_ld = 1'b0; is_st = 1'b1; ls_addr = 32'h9000; st_data = 32'h55;
        size = 3'd4; zero_ext = 1'b0; mis = 1'b0; dbus_ack = 1'b0;
        @(posedge clk_in); #1;
        req_valid = 1'b0; is_st = 1'b0;
        @(negedge clk_in);
        n_checks++;
        if (dbus_req !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_bus_pre got req=%b exp=1", dbus_req);
        end
        #2 reset_in = 1'b1;
        #1;
        n_checks++;
        if ({dbus_req, dbus_wr, req_ready, rsp_valid} !== 4'b0010) begin
            n_fail++;
            $display("FAIL reset_mid_bus got req/wr/ready/rsp=%b exp=0010",
                     {dbus_req, dbus_wr, req_ready, rsp_valid});
        end
        @(posedge clk_in); #1;
        reset_in = 1'b0;
        @(negedge clk_in);
        n_checks++;
        if ({dbus_req, rsp_valid, req_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL reset_mid_bus_post got req/rsp/ready=%b exp=001",
                     {dbus_req, rsp_valid, req_ready});
        end
        @(posedge clk_in); #1;
        run_txn(1, 32'h9004, 32'h0, 2, 0, 0, 0, 0, 32'h0000_F00F, -1, be, wd, d);
    endtask

    task automatic test_random();
        logic [3:0] be; logic [31:0] wd, d;
        int sz, off, r, ack_delay, flush_at;
        bit ld, misal, fault;
        logic [31:0] base;
        for (int n = 0; n < 60; n++) begin
            r     = $urandom_range(0, 2);
            sz    = (r == 0) ? 1 : ((r == 1) ? 2 : 4);
            ld    = 1'($urandom_range(0, 1));
            misal = (sz > 1) && ($urandom_range(0, 5) == 0);
            base  = $urandom & 32'hFFFF_FFFC;
            if (misal) off = (sz == 2) ? 2 * $urandom_range(0, 1) + 1 : $urandom_range(1, 3);
            else if (sz == 1) off = $urandom_range(0, 3);
            else if (sz == 2) off = 2 * $urandom_range(0, 1);
            else off = 0;
            r = $urandom_range(0, 9);
            ack_delay = (r == 9) ? 100 : ((r == 8) ? TO - 1 : $urandom_range(0, 3));
            fault     = ($urandom_range(0, 7) == 0);
            flush_at  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 4) : -1;
            run_txn(ld, base | 32'(off), $urandom, sz, 1'($urandom_range(0, 1)), misal,
                    ack_delay, fault, $urandom, flush_at, be, wd, d);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_flush();
        test_ack_idle();
        test_reset_mid_bus();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog simulation did not complete in time");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
